// File: rtl/echo_ranger_if.sv
// rtl/echo_ranger_if.sv - handshake and result signals between controller and ranger
// The master side arms measurements and drives echo; the slave side is the ranger.
interface echo_ranger_if;
  logic       start;
  logic       echo;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [9:0] distance_cm;

  modport master (
    output start,
    output echo,
    input  busy,
    input  done,
    input  timeout,
    input  distance_cm
  );

  modport slave (
    input  start,
    input  echo,
    output busy,
    output done,
    output timeout,
    output distance_cm
  );
endinterface

// File: rtl/echo_ranger.sv
// rtl/echo_ranger.sv - ultrasonic echo pulse-width ranger
// Converts a synchronized echo pulse width into whole centimetres by counting without a divider.
module echo_ranger #(
  parameter int CLK_PER_CM = 2900,
  parameter int WAIT_LIMIT = 1500000,
  parameter int ECHO_LIMIT = 1900000
) (
  input  logic            clk,
  input  logic            rst_n,
  echo_ranger_if.slave    bus
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam int CW = $clog2(ECHO_LIMIT + 1);
  localparam int SW = $clog2(CLK_PER_CM + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HIGH,
    MEASURE,
    DONE
  } state_t;

  state_t          r_state;
  logic            r_echo_s1;
  logic            r_echo_s2;
  logic            r_echo_d;
  logic            r_rise;
  logic            r_fall;
  logic [WW-1:0]   r_wait_cnt;
  logic [CW-1:0]   r_cycle_cnt;
  logic [SW-1:0]   r_sub_cnt;
  logic [9:0]      r_cm_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;
  logic [9:0]      r_distance;

  logic            w_rise;
  logic            w_fall;
  logic            w_sub_wrap;
  logic [SW-1:0]   w_sub_next;
  logic [9:0]      w_cm_next;

  assign w_rise     = r_echo_s2 & ~r_echo_d;
  assign w_fall     = ~r_echo_s2 & r_echo_d;
  assign w_sub_wrap = (r_sub_cnt == SW'(CLK_PER_CM - 1));
  assign w_sub_next = w_sub_wrap ? '0 : r_sub_cnt + 1'b1;
  assign w_cm_next  = (w_sub_wrap && r_cm_cnt != 10'h3FF) ? r_cm_cnt + 10'd1 : r_cm_cnt;

  // Edge pulses are registered so the rise->MEASURE and fall->DONE paths see
  // identical latency, which makes the MEASURE cycle count equal the pulse width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_echo_s1   <= 1'b0;
      r_echo_s2   <= 1'b0;
      r_echo_d    <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_wait_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_sub_cnt   <= '0;
      r_cm_cnt    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_distance  <= '0;
    end else begin
      r_echo_s1 <= bus.echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_rise    <= w_rise;
      r_fall    <= w_fall;
      r_done    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= WAIT_HIGH;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
          end
        end

        WAIT_HIGH: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (r_rise) begin
            r_state     <= MEASURE;
            r_cycle_cnt <= '0;
            r_sub_cnt   <= '0;
            r_cm_cnt    <= '0;
          end else if (r_wait_cnt == WW'(WAIT_LIMIT - 1)) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
            r_distance <= 10'h3FF;
          end
        end

        MEASURE: begin
          // Echo is high for every MEASURE cycle, including the one that sees the fall.
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
          r_sub_cnt   <= w_sub_next;
          r_cm_cnt    <= w_cm_next;
          if (r_fall) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_timeout  <= 1'b0;
            r_distance <= w_cm_next;
          end else if (r_cycle_cnt == CW'(ECHO_LIMIT - 1)) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
            r_distance <= 10'h3FF;
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.distance_cm = r_distance;

endmodule

// File: tb/tb_echo_ranger.sv
// tb/tb_echo_ranger.sv - directed self-checking bench for echo_ranger
// Uses scaled limits so every scenario, including both timeouts, runs in a few thousand cycles.
module tb_echo_ranger;
  localparam int CPC = 29;
  localparam int WL  = 500;
  localparam int EL  = 600;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  echo_ranger_if bus();

  echo_ranger #(
    .CLK_PER_CM(CPC),
    .WAIT_LIMIT(WL),
    .ECHO_LIMIT(EL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic send_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive_pulse(input int width);
    @(negedge clk);
    bus.echo = 1'b1;
    repeat (width) @(negedge clk);
    bus.echo = 1'b0;
  endtask

  // Counts falling edges until done is seen; an expired bound returns bound+1.
  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) return;
    end
    n = bound + 1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.echo  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.timeout); end
    checks++; if (bus.distance_cm !== 10'd0) begin errors++; $display("FAIL reset_dist got %0d exp 0", bus.distance_cm); end
    rst_n     = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_first_start busy got %b exp 1", bus.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    send_start();
    repeat (2) @(negedge clk);
    drive_pulse(290);
    wait_done(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", n); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b exp 0", bus.timeout); end
    checks++; if (bus.distance_cm !== 10'd10) begin errors++; $display("FAIL basic_dist got %0d exp 10", bus.distance_cm); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", bus.busy); end
  endtask

  task automatic test_boundaries();
    int w [4] = '{28, 29, 57, 58};
    int d [4] = '{0, 1, 1, 2};
    int n;
    for (int i = 0; i < 4; i++) begin
      send_start();
      repeat (2) @(negedge clk);
      drive_pulse(w[i]);
      wait_done(20, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL bound_latency w=%0d got %0d exp 4", w[i], n); end
      checks++; if (bus.distance_cm !== 10'(d[i])) begin errors++; $display("FAIL bound_dist w=%0d got %0d exp %0d", w[i], bus.distance_cm, d[i]); end
      checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL bound_timeout w=%0d got %b exp 0", w[i], bus.timeout); end
      @(negedge clk);
    end
  endtask

  task automatic test_pre_high();
    int n;
    @(negedge clk);
    bus.echo = 1'b1;
    repeat (10) @(negedge clk);
    send_start();
    repeat (5) @(negedge clk);
    bus.echo = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL prehigh_still_waiting busy got %b exp 1", bus.busy); end
    drive_pulse(290);
    wait_done(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL prehigh_latency got %0d exp 4", n); end
    checks++; if (bus.distance_cm !== 10'd10) begin errors++; $display("FAIL prehigh_dist got %0d exp 10", bus.distance_cm); end
    @(negedge clk);
  endtask

  task automatic test_restart_in_measure();
    int n;
    send_start();
    repeat (2) @(negedge clk);
    bus.echo = 1'b1;
    repeat (100) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (189) @(negedge clk);
    bus.echo = 1'b0;
    wait_done(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL restart_latency got %0d exp 4", n); end
    checks++; if (bus.distance_cm !== 10'd10) begin errors++; $display("FAIL restart_dist got %0d exp 10", bus.distance_cm); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.start = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done busy got %b exp 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_start_after_done busy got %b exp 1", bus.busy); end
    repeat (2) @(negedge clk);
    drive_pulse(58);
    wait_done(20, n);
    checks++; if (bus.distance_cm !== 10'd2) begin errors++; $display("FAIL b2b_dist got %0d exp 2", bus.distance_cm); end
    @(negedge clk);
  endtask

  task automatic test_fall_vs_limit();
    int n;
    send_start();
    repeat (2) @(negedge clk);
    drive_pulse(EL);
    wait_done(20, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL tie_latency got %0d exp 4", n); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL tie_timeout got %b exp 0", bus.timeout); end
    checks++; if (bus.distance_cm !== 10'd20) begin errors++; $display("FAIL tie_dist got %0d exp 20", bus.distance_cm); end
    @(negedge clk);
  endtask

  task automatic test_wait_timeout();
    int n;
    send_start();
    wait_done(WL + 20, n);
    checks++; if (n + 1 !== WL + 1) begin errors++; $display("FAIL waitto_latency got %0d exp %0d", n + 1, WL + 1); end
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL waitto_timeout got %b exp 1", bus.timeout); end
    checks++; if (bus.distance_cm !== 10'h3FF) begin errors++; $display("FAIL waitto_dist got %h exp 3ff", bus.distance_cm); end
    @(negedge clk);
  endtask

  task automatic test_echo_timeout();
    int n;
    int pulses;
    send_start();
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.echo = 1'b1;
    wait_done(EL + 20, n);
    checks++; if (n !== EL + 4) begin errors++; $display("FAIL echoto_latency got %0d exp %0d", n, EL + 4); end
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL echoto_timeout got %b exp 1", bus.timeout); end
    checks++; if (bus.distance_cm !== 10'h3FF) begin errors++; $display("FAIL echoto_dist got %h exp 3ff", bus.distance_cm); end
    repeat (100) @(negedge clk);
    bus.echo = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL echoto_late_fall done pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    send_start();
    repeat (2) @(negedge clk);
    bus.echo = 1'b1;
    repeat (145) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (145) @(negedge clk);
    bus.echo = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_done pulses got %0d exp 0", pulses); end
    checks++; if (bus.distance_cm !== 10'd0) begin errors++; $display("FAIL rstmid_dist got %0d exp 0", bus.distance_cm); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL rstmid_timeout got %b exp 0", bus.timeout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_pre_high();
    test_restart_in_measure();
    test_back_to_back();
    test_fall_vs_limit();
    test_wait_timeout();
    test_echo_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/echo_ranger.md
ECHO_RANGER -- requirements
Module: echo_ranger

Interface
REQ-001 Parameter CLK_PER_CM, default 2900, meaning clk cycles of echo high time per centimetre (58 us at 50 MHz).
REQ-002 Parameter WAIT_LIMIT, default 1500000, meaning maximum cycles from start to echo rise (30 ms).
REQ-003 Parameter ECHO_LIMIT, default 1900000, meaning maximum cycles echo may stay high (38 ms).
REQ-004 Port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port start  input  1  one-cycle request to arm a measurement, synchronous to clk.
REQ-007 Port echo  input  1  sensor echo line, asynchronous to clk.
REQ-008 Port busy  output  1  high while a measurement is in progress (any state other than IDLE).
REQ-009 Port done  output  1  one-cycle pulse marking completion of a measurement.
REQ-010 Port timeout  output  1  error flag for the last completed measurement.
REQ-011 Port distance_cm  output  10  last measured distance in whole centimetres.

Function
REQ-012 echo SHALL pass through a two-flop synchronizer; edges SHALL be detected on the synchronized signal against a one-cycle delayed copy.
REQ-013 States SHALL be: IDLE, WAIT_HIGH, MEASURE, DONE.
REQ-014 IDLE: start=1 -> WAIT_HIGH, clearing wait counter; start in any other state SHALL be ignored.
REQ-015 WAIT_HIGH: synchronized rising edge -> MEASURE, clearing cycle counter, sub-counter and cm counter; an echo already high on entry SHALL NOT count, and only a fresh rising edge starts measurement.
REQ-016 WAIT_HIGH: wait counter reaching WAIT_LIMIT-1 with no rising edge -> DONE with timeout result.
REQ-017 MEASURE: per cycle of synchronized echo high, sub-counter SHALL increment; at CLK_PER_CM-1 it SHALL wrap to 0 and the cm counter SHALL increment, saturating at 1023.
REQ-018 Distance SHALL equal floor(high_cycles / CLK_PER_CM); no divider, no rounding.
REQ-019 MEASURE: synchronized falling edge -> DONE with valid result; cycle counter reaching ECHO_LIMIT-1 -> DONE with timeout result.
REQ-020 Falling edge and ECHO_LIMIT in the same cycle: the falling edge SHALL win (valid result).
REQ-021 DONE: lasts exactly one cycle, done=1, then IDLE; distance_cm and timeout update in this cycle and hold until the next DONE.
REQ-022 Valid result: timeout=0, distance_cm=cm counter; timeout result: timeout=1, distance_cm=10'h3FF.
REQ-023 done SHALL assert exactly 3 clk cycles after the first rising clk edge that samples echo low at the end of a pulse.
REQ-024 Measured high_cycles SHALL equal the echo pulse width in clk cycles (equal synchronizer delay on both edges).
REQ-025 start arriving in the DONE cycle SHALL be ignored; start is accepted from IDLE one cycle later.

Reset
REQ-026 rst_n=0 at a rising clk edge SHALL force IDLE and clear all counters, synchronizer flops, busy, done and timeout, and set distance_cm=0.
REQ-027 Reset mid-measurement SHALL abort with no done pulse; the next measurement requires a new start.
REQ-028 With rst_n=1, the first start SHALL be accepted on the first rising clk edge after release.

Verification
REQ-029 start, echo high 29000 cycles -> one done pulse, timeout=0, distance_cm=10, busy low after DONE.
REQ-030 Boundary widths: 2899 -> 0; 2900 -> 1; 5799 -> 1; 5800 -> 2 cm.
REQ-031 start, echo never rises -> done at WAIT_LIMIT+1 cycles after start, timeout=1, distance_cm=3FF; echo held high 2000000 cycles -> timeout=1 after ECHO_LIMIT.
REQ-032 echo already high at start, falls, then 29000-cycle pulse -> distance_cm=10 (partial pulse ignored).
REQ-033 rst_n low for 1 cycle midway through a 29000-cycle pulse -> no done, distance_cm=0, busy=0; repeated start in MEASURE -> no effect on result.
